// File: rtl/cook_sequencer_if.sv
// rtl/cook_sequencer_if.sv - keypad/button inputs and display/magnetron outputs of the cook sequencer
interface cook_sequencer_if;
    logic       Nstart;
    logic       Nstop;
    logic       Nclear;
    logic       door_clo;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic       time_over;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [1:0] state;
    logic       done_alarm;

    // Panel side: drives buttons, door and keypad; observes display and magnetron
    modport master (
        output Nstart, Nstop, Nclear, door_clo, key_valid, key_digit,
        input  mag_on, time_over, min_tens, min_ones, sec_tens, sec_ones, state, done_alarm
    );

    // Controller side
    modport slave (
        input  Nstart, Nstop, Nclear, door_clo, key_valid, key_digit,
        output mag_on, time_over, min_tens, min_ones, sec_tens, sec_ones, state, done_alarm
    );
endinterface

// File: rtl/cook_sequencer.sv
// rtl/cook_sequencer.sv - microwave cooking controller: keypad entry, MM:SS countdown, cook/pause/done sequencing
module cook_sequencer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int DONE_HOLD     = 3
) (
    input  logic           clk,
    input  logic           rst,
    cook_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PRESC_W      = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int ALARM_CYCLES = DONE_HOLD * TICKS_PER_SEC;
    localparam int ALARM_W      = $clog2(ALARM_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [ALARM_W-1:0] ALARM_LOAD = ALARM_W'(ALARM_CYCLES);

    // Button bit order in the sync/history vectors: {start, stop, clear}
    state_t             state_q, state_d;
    logic [15:0]        digits_q, digits_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic               done_alarm_q, done_alarm_d;
    logic [2:0]         btn_sync_q, btn_sync_d;
    logic [2:0]         btn_hist_q, btn_hist_d;

    logic        ev_start;
    logic        ev_stop;
    logic        ev_clear;
    logic        terminal;
    logic        time_zero;
    logic        key_ok;
    logic [15:0] digits_dec;

    // One-second BCD decrement of MM:SS; seconds above 59 simply count down
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            so = 4'd9;
        end else if ({mt, mo} != 8'd0) begin
            st = 4'd5;
            so = 4'd9;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mt = mt - 4'd1;
                mo = 4'd9;
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Falling-edge events on the registered button copies, plus shared decodes
    always_comb begin
        ev_start   = btn_hist_q[2] & ~btn_sync_q[2];
        ev_stop    = btn_hist_q[1] & ~btn_sync_q[1];
        ev_clear   = btn_hist_q[0] & ~btn_sync_q[0];
        terminal   = (presc_q == PRESC_TERM);
        time_zero  = (digits_q == 16'd0);
        key_ok     = bus.key_valid && (bus.key_digit <= 4'd9);
        digits_dec = bcd_dec(digits_q);
    end

    // Next-state logic; the if/else order inside each state encodes the event priority
    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        presc_d      = presc_q;
        alarm_cnt_d  = alarm_cnt_q;
        done_alarm_d = done_alarm_q;
        btn_sync_d   = {bus.Nstart, bus.Nstop, bus.Nclear};
        btn_hist_d   = btn_sync_q;

        if (ev_clear) begin
            state_d      = IDLE;
            digits_d     = 16'd0;
            presc_d      = '0;
            alarm_cnt_d  = '0;
            done_alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_stop) begin
                        digits_d = 16'd0;
                    end else if (ev_start && bus.door_clo && !time_zero) begin
                        state_d = COOK;
                        presc_d = '0;
                    end else if (ev_start) begin
                        state_d = IDLE;
                    end else if (key_ok) begin
                        digits_d = {digits_q[11:0], bus.key_digit};
                    end
                end
                COOK: begin
                    if (ev_stop || !bus.door_clo) begin
                        state_d = PAUSE;
                    end else if (terminal) begin
                        presc_d  = '0;
                        digits_d = digits_dec;
                        if (digits_dec == 16'd0) begin
                            state_d      = DONE;
                            alarm_cnt_d  = ALARM_LOAD;
                            done_alarm_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                PAUSE: begin
                    if (ev_stop) begin
                        state_d  = IDLE;
                        digits_d = 16'd0;
                    end else if (ev_start && bus.door_clo) begin
                        state_d = COOK;
                        presc_d = '0;
                    end
                end
                DONE: begin
                    if (ev_stop || !bus.door_clo) begin
                        state_d      = IDLE;
                        alarm_cnt_d  = '0;
                        done_alarm_d = 1'b0;
                    end else if (alarm_cnt_q != '0) begin
                        alarm_cnt_d  = alarm_cnt_q - ALARM_W'(1);
                        done_alarm_d = (alarm_cnt_q != ALARM_W'(1));
                    end else begin
                        done_alarm_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers; button history resets high so no edge is seen out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            digits_q     <= 16'd0;
            presc_q      <= '0;
            alarm_cnt_q  <= '0;
            done_alarm_q <= 1'b0;
            btn_sync_q   <= 3'b111;
            btn_hist_q   <= 3'b111;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            presc_q      <= presc_d;
            alarm_cnt_q  <= alarm_cnt_d;
            done_alarm_q <= done_alarm_d;
            btn_sync_q   <= btn_sync_d;
            btn_hist_q   <= btn_hist_d;
        end
    end

    // Outputs are direct decodes of registered state
    assign bus.mag_on     = (state_q == COOK);
    assign bus.time_over  = (state_q == DONE);
    assign bus.state      = state_q;
    assign bus.done_alarm = done_alarm_q;
    assign bus.min_tens   = digits_q[15:12];
    assign bus.min_ones   = digits_q[11:8];
    assign bus.sec_tens   = digits_q[7:4];
    assign bus.sec_ones   = digits_q[3:0];
endmodule

// File: tb/tb_cook_sequencer.sv
// tb/tb_cook_sequencer.sv - self-checking bench for cook_sequencer
module tb_cook_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cook_sequencer_if bus_if ();

    cook_sequencer #(.TICKS_PER_SEC(4), .DONE_HOLD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ns, np, nc, door, kv;
        logic [3:0]  kd;
        int          n;
        logic [1:0]  st;
        logic [15:0] disp;
        logic        mag, tov, al;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ns, logic np, logic nc, logic door, logic kv, logic [3:0] kd,
                                int n, logic [1:0] st, logic [15:0] disp, logic mag, logic tov, logic al);
        vec_t v;
        v.ns = ns; v.np = np; v.nc = nc; v.door = door; v.kv = kv; v.kd = kd; v.n = n;
        v.st = st; v.disp = disp; v.mag = mag; v.tov = tov; v.al = al;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic ns, logic np, logic nc, logic door, logic kv, logic [3:0] kd);
        bus_if.Nstart    = ns;
        bus_if.Nstop     = np;
        bus_if.Nclear    = nc;
        bus_if.door_clo  = door;
        bus_if.key_valid = kv;
        bus_if.key_digit = kd;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string nm, logic [1:0] st, logic [15:0] disp, logic mag, logic tov, logic al);
        chk({nm, ".state"}, int'(bus_if.state), int'(st));
        chk({nm, ".disp"}, int'({bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones}), int'(disp));
        chk({nm, ".mag_on"}, int'(bus_if.mag_on), int'(mag));
        chk({nm, ".time_over"}, int'(bus_if.time_over), int'(tov));
        chk({nm, ".done_alarm"}, int'(bus_if.done_alarm), int'(al));
    endtask

    task automatic chk_st(string nm, logic [1:0] st, logic [15:0] disp);
        chk({nm, ".state"}, int'(bus_if.state), int'(st));
        chk({nm, ".disp"}, int'({bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones}), int'(disp));
    endtask

    task automatic key(logic [3:0] d);
        bus_if.key_valid = 1'b1;
        bus_if.key_digit = d;
        tick();
        bus_if.key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus_if.Nstart = 1'b0; tick();
        bus_if.Nstart = 1'b1; tick();
    endtask

    task automatic pulse_stop();
        bus_if.Nstop = 1'b0; tick();
        bus_if.Nstop = 1'b1; tick();
    endtask

    task automatic pulse_clear();
        bus_if.Nclear = 1'b0; tick();
        bus_if.Nclear = 1'b1; tick();
    endtask

    initial begin
        drive(1, 1, 1, 1, 0, 4'd0);
        rst = 1'b1;
        tick(); tick();
        chk_all("reset", 2'd0, 16'h0000, 0, 0, 0);
        rst = 1'b0;

        // Cook 01:05 countdown, then stop/stop, then a 00:02 run to DONE and alarm timeout
        tbl.push_back(mk(1, 1, 1, 1, 1, 4'd1,  1, 2'd0, 16'h0001, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 4'd0,  1, 2'd0, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 4'd5,  1, 2'd0, 16'h0105, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0,  1, 2'd0, 16'h0105, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  1, 2'd1, 16'h0105, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  4, 2'd1, 16'h0104, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0, 16, 2'd1, 16'h0100, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  4, 2'd1, 16'h0059, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 4'd0,  1, 2'd1, 16'h0059, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  1, 2'd2, 16'h0059, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 4'd0,  1, 2'd2, 16'h0059, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  1, 2'd0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 4'd0,  3, 2'd0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 4'd2,  1, 2'd0, 16'h0002, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0,  1, 2'd0, 16'h0002, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  1, 2'd1, 16'h0002, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  4, 2'd1, 16'h0001, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  3, 2'd1, 16'h0001, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  1, 2'd3, 16'h0000, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 4'd7,  7, 2'd3, 16'h0000, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  1, 2'd3, 16'h0000, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 4'd0,  1, 2'd3, 16'h0000, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0,  1, 2'd0, 16'h0000, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ns, tbl[i].np, tbl[i].nc, tbl[i].door, tbl[i].kv, tbl[i].kd);
            for (int k = 0; k < tbl[i].n; k++) tick();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].disp, tbl[i].mag, tbl[i].tov, tbl[i].al);
        end
        drive(1, 1, 1, 1, 0, 4'd0);

        // Door opens on a terminal-tick cycle at 00:30
        key(4'd3); key(4'd0);
        pulse_start();
        chk_st("door.cook", 2'd1, 16'h0030);
        tick(); tick(); tick();
        bus_if.door_clo = 1'b0;
        tick();
        chk_all("door.pause", 2'd2, 16'h0030, 0, 0, 0);
        pulse_start();
        tick(); tick();
        chk_st("door.open_start", 2'd2, 16'h0030);
        bus_if.door_clo = 1'b1;
        pulse_start();
        chk_all("door.resume", 2'd1, 16'h0030, 1, 0, 0);
        tick(); tick(); tick();
        chk_st("door.pre_dec", 2'd1, 16'h0030);
        tick();
        chk_st("door.dec", 2'd1, 16'h0029);

        // Stop mid-cook at 00:15, second stop clears, start at 00:00 ignored
        pulse_clear();
        chk_st("stop.clear", 2'd0, 16'h0000);
        key(4'd1); key(4'd5);
        pulse_start();
        pulse_stop();
        chk_all("stop.pause", 2'd2, 16'h0015, 0, 0, 0);
        repeat (6) tick();
        chk_st("stop.held", 2'd2, 16'h0015);
        pulse_stop();
        chk_st("stop.idle", 2'd0, 16'h0000);
        pulse_start();
        chk_all("stop.zero_start", 2'd0, 16'h0000, 0, 0, 0);

        // Clear beats start, bad digit ignored, held start fires once
        key(4'd0); key(4'd9);
        chk_st("prio.entry", 2'd0, 16'h0009);
        bus_if.Nclear = 1'b0; bus_if.Nstart = 1'b0; tick();
        bus_if.Nclear = 1'b1; bus_if.Nstart = 1'b1; tick();
        chk_all("prio.clear", 2'd0, 16'h0000, 0, 0, 0);
        key(4'd5);
        key(4'd12);
        chk_st("prio.bad_digit", 2'd0, 16'h0005);
        bus_if.Nstart = 1'b0;
        tick(); tick();
        chk_st("hold.cook", 2'd1, 16'h0005);
        bus_if.Nstop = 1'b0; tick();
        bus_if.Nstop = 1'b1; tick();
        chk_st("hold.pause", 2'd2, 16'h0005);
        repeat (6) tick();
        chk_st("hold.once", 2'd2, 16'h0005);
        bus_if.Nstart = 1'b1; tick();
        chk_st("hold.release", 2'd2, 16'h0005);
        pulse_clear();

        // Key ignored in COOK, then reset mid-cook
        key(4'd4); key(4'd0);
        pulse_start();
        key(4'd7);
        chk_all("rst.cook_key", 2'd1, 16'h0040, 1, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk_all("rst.mid", 2'd0, 16'h0000, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_all("rst.after", 2'd0, 16'h0000, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
